pix_downscaler: RTL

Streaming 3:2 horizontal pixel downscaler: every three input pixels of a line are resampled to two output pixels by weighted linear interpolation. It is the reducing counterpart of the pixel upscaler on the same pixel bus, and it uses the same fixed-point ×1/3 multiply approach. The block sits between the line source and the sensor/output formatter, in the single pixel clock domain.

---
 rtl/pix_downscaler_pkg.sv | 30 +++
 rtl/pix_div3.sv | 40 ++++
 rtl/pix_downscaler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pix_downscaler_pkg.sv
// Shared pixel-bus definitions: group phase enum, x1/3 reciprocal constants and sum width.
package pix_downscaler_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

  // A weighted sum of three pixels needs two guard bits above the pixel width.
  localparam int unsigned SUM_GUARD_W = 32'd2;

  function automatic int unsigned sum_w_f(input int unsigned data_w);
    return data_w + SUM_GUARD_W;
  endfunction

  function automatic int unsigned shift_f(input int unsigned data_w);
    return data_w + 32'd3;
  endfunction

  // ceil(2^(data_w+3) / 3)
  function automatic int unsigned recip_f(input int unsigned data_w);
    return ((32'd1 << shift_f(data_w)) + 32'd2) / 32'd3;
  endfunction

  function automatic int unsigned prod_w_f(input int unsigned data_w);
    return (32'd2 * data_w) + 32'd5;
  endfunction

endpackage

// File: rtl/pix_div3.sv
// Registered divide-by-three: multiply by the fixed-point reciprocal, then shift down.
module pix_div3
  import pix_downscaler_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [sum_w_f(DATA_W)-1:0] s_i,
  input  logic                      rnd_i,
  output logic [DATA_W-1:0]         q_o
);

  localparam int unsigned PW    = prod_w_f(DATA_W);
  localparam int unsigned SHIFT = shift_f(DATA_W);
  localparam int unsigned RECIP = recip_f(DATA_W);

  logic [PW-1:0]     prod_s;
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  // The reciprocal is accurate enough that the shifted product is an exact floor(x/3).
  always_comb begin
    prod_s = (PW'(s_i) + PW'(rnd_i)) * PW'(RECIP);
    q_d    = DATA_W'(prod_s >> SHIFT);
  end

  // Result register; holds while no new sum is presented.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pix_downscaler.sv
// Streaming 3:2 horizontal pixel downscaler with 2-cycle latency.
// Optional build macro PIX_DS_ROUND_EN: round-to-nearest instead of floor.
module pix_downscaler
  import pix_downscaler_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              line_start,
  input  logic              line_end,
  input  logic [DATA_W-1:0] input_pix,
  output logic              output_valid,
  output logic [DATA_W-1:0] output_pix,
  output logic              output_line_start,
  output logic              output_line_end
);

  localparam int unsigned SW = sum_w_f(DATA_W);

`ifdef PIX_DS_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  phase_e            phase_q, phase_d, eph_s;
  logic [DATA_W-1:0] p0_q, p0_d, p1_q, p1_d;
  logic              start_pend_q, start_pend_d, pend_s;
  logic              a_valid_q, a_valid_d;
  logic              a_ls_q, a_ls_d, a_le_q, a_le_d;
  logic [SW-1:0]     a_sum_q, a_sum_d;
  logic [SW-1:0]     pix_w_s, p0_w_s, p1_w_s;
  logic              out_valid_q, out_ls_q, out_le_q;

  // Stage A decode: phase advance, group storage and weighted sum selection.
  always_comb begin
    phase_d      = phase_q;
    p0_d         = p0_q;
    p1_d         = p1_q;
    start_pend_d = start_pend_q;
    a_valid_d    = 1'b0;
    a_ls_d       = a_ls_q;
    a_le_d       = a_le_q;
    a_sum_d      = a_sum_q;
    pix_w_s      = SW'(input_pix);
    p0_w_s       = SW'(p0_q);
    p1_w_s       = SW'(p1_q);
    eph_s        = line_start ? PH0 : phase_q;
    pend_s       = start_pend_q | line_start;
    if (enable) begin
      case (eph_s)
        PH0: begin
          p0_d = input_pix;
          if (line_end) begin
            a_valid_d = 1'b1;
            a_sum_d   = pix_w_s + pix_w_s + pix_w_s;
            phase_d   = PH0;
          end else begin
            phase_d   = PH1;
          end
        end
        PH1: begin
          p1_d      = input_pix;
          a_valid_d = 1'b1;
          a_sum_d   = p0_w_s + p0_w_s + pix_w_s;
          phase_d   = line_end ? PH0 : PH2;
        end
        PH2: begin
          a_valid_d = 1'b1;
          a_sum_d   = p1_w_s + pix_w_s + pix_w_s;
          phase_d   = PH0;
        end
        default: begin
          phase_d = PH0;
        end
      endcase
      // The start flag waits for the first output the new line actually produces.
      if (a_valid_d) begin
        a_ls_d       = pend_s;
        a_le_d       = line_end;
        start_pend_d = 1'b0;
      end else begin
        start_pend_d = pend_s;
      end
    end else begin
      a_valid_d = 1'b0;
    end
  end

  // Phase, stored pixels and stage A registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      phase_q      <= PH0;
      p0_q         <= '0;
      p1_q         <= '0;
      start_pend_q <= 1'b0;
      a_valid_q    <= 1'b0;
      a_ls_q       <= 1'b0;
      a_le_q       <= 1'b0;
      a_sum_q      <= '0;
    end else begin
      phase_q      <= phase_d;
      p0_q         <= p0_d;
      p1_q         <= p1_d;
      start_pend_q <= start_pend_d;
      a_valid_q    <= a_valid_d;
      a_ls_q       <= a_ls_d;
      a_le_q       <= a_le_d;
      a_sum_q      <= a_sum_d;
    end
  end

  pix_div3 #(
    .DATA_W (DATA_W)
  ) u_div3 (
    .clk_in (clk_in),
    .rst    (rst),
    .load_i (a_valid_q),
    .s_i    (a_sum_q),
    .rnd_i  (RND),
    .q_o    (output_pix)
  );

  // Stage B flags, aligned with the divider register; they hold across idle slots.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ls_q    <= 1'b0;
      out_le_q    <= 1'b0;
    end else begin
      out_valid_q <= a_valid_q;
      if (a_valid_q) begin
        out_ls_q <= a_ls_q;
        out_le_q <= a_le_q;
      end
    end
  end

  assign output_valid      = out_valid_q;
  assign output_line_start = out_ls_q;
  assign output_line_end   = out_le_q;

endmodule
